// File: rtl/bayes_pkg.sv
`default_nettype none
// bayes_pkg: sequencer state encoding, default classifier sizes and index-width helper.
package bayes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int BAYES_N_CLASS = 10;
  localparam int BAYES_N_ATTR  = 784;

  // A 1-entry range still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bayes_wrap_cnt.sv
`default_nettype none
// bayes_wrap_cnt: 0..MAX-1 counter with increment enable, clear and a wrap flag
// (wrap is high on the increment that returns the count to zero).
module bayes_wrap_cnt #(
  parameter int MAX = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  assign at_max = (cnt == LAST);
  assign wrap   = inc & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= at_max ? '0 : cnt + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bayes_idx_seq.sv
`default_nettype none
// bayes_idx_seq: class-major (class, attribute) index sequencer on a valid/ready stream.
// Optional BAYES_IDX_ADDR_EN adds an incrementally maintained linear address output.
module bayes_idx_seq
  import bayes_pkg::*;
#(
  parameter int N_CLASS = BAYES_N_CLASS,
  parameter int N_ATTR  = BAYES_N_ATTR,
  parameter int C_W     = idx_width(N_CLASS),
  parameter int A_W     = idx_width(N_ATTR)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [C_W-1:0] out_c_idx,
  output logic [A_W-1:0] out_attri_idx,
  output logic           out_attr_last,
  output logic           out_class_last
`ifdef BAYES_IDX_ADDR_EN
  ,
  output logic [C_W+A_W-1:0] out_addr
`endif
);

  state_t state, state_nxt;
  logic   xfer, step, clr;
  logic   a_max, a_wrap, c_max, c_wrap;

  assign xfer = out_valid & out_ready;
  // Abort outranks a simultaneous handshake: that beat is not counted.
  assign step = xfer & ~abort;
  assign clr  = abort | ((state == ST_IDLE) & start);

  bayes_wrap_cnt #(.MAX(N_ATTR), .W(A_W)) u_attr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (step),
    .cnt    (out_attri_idx),
    .at_max (a_max),
    .wrap   (a_wrap)
  );

  bayes_wrap_cnt #(.MAX(N_CLASS), .W(C_W)) u_class_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .inc    (a_wrap),
    .cnt    (out_c_idx),
    .at_max (c_max),
    .wrap   (c_wrap)
  );

  // c_wrap marks the accepted final beat of the sweep.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start && !abort) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort)       state_nxt = ST_IDLE;
        else if (c_wrap) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == ST_RUN);
      busy      <= (state_nxt == ST_RUN);
      done      <= (state_nxt == ST_DONE);
    end
  end

  assign out_attr_last  = out_valid & a_max;
  assign out_class_last = out_valid & c_max;

`ifdef BAYES_IDX_ADDR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr <= '0;
    end else if (clr || c_wrap) begin
      out_addr <= '0;
    end else if (step) begin
      out_addr <= out_addr + (C_W + A_W)'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bayes_idx_seq.sv
`default_nettype none
// tb_bayes_idx_seq: vector table and scoreboard checks on a small (3x4) and a default (10x784) sequencer.
module tb_bayes_idx_seq;

  localparam int NC = 10;
  localparam int NA = 784;
  localparam int SC = 3;
  localparam int SA = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0;
  logic b_busy, b_done, b_valid, b_al, b_cl;
  logic [3:0] b_c;
  logic [9:0] b_a;

  logic s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b0;
  logic s_busy, s_done, s_valid, s_al, s_cl;
  logic [1:0] s_c, s_a;

`ifdef BAYES_IDX_ADDR_EN
  logic [13:0] b_addr;
  logic [3:0]  s_addr;
`endif

  bayes_idx_seq #(.N_CLASS(NC), .N_ATTR(NA)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .out_valid(b_valid), .out_ready(b_ready),
    .out_c_idx(b_c), .out_attri_idx(b_a),
    .out_attr_last(b_al), .out_class_last(b_cl)
`ifdef BAYES_IDX_ADDR_EN
    , .out_addr(b_addr)
`endif
  );

  bayes_idx_seq #(.N_CLASS(SC), .N_ATTR(SA)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .busy(s_busy), .done(s_done), .out_valid(s_valid), .out_ready(s_ready),
    .out_c_idx(s_c), .out_attri_idx(s_a),
    .out_attr_last(s_al), .out_class_last(s_cl)
`ifdef BAYES_IDX_ADDR_EN
    , .out_addr(s_addr)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [1:0] c;
    logic [1:0] a;
    logic       al;
    logic       cl;
  } beat_t;

  beat_t sb[$];

  typedef struct {
    logic st, ab, rdy;
    logic v, b, d;
    int   c, a;
    logic al;
  } vec_t;

  vec_t vt[16];

  // Scoreboard monitor on the small instance, active only during the backpressure run.
  logic       mon_en  = 1'b0;
  int         s_dones = 0;
  int         s_beats = 0;
  initial begin
    logic  pv, pr;
    beat_t prev, cur, e;
    pv = 1'b0; pr = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      cur = '{c: s_c, a: s_a, al: s_al, cl: s_cl};
      if (mon_en) begin
        if (pv && !pr) chk("bp_hold", {s_valid, cur}, {1'b1, prev});
        if (s_done) s_dones++;
        if (s_valid && s_ready) begin
          s_beats++;
          if (sb.size() == 0) chk("bp_extra_beat", {26'd0, cur}, 32'hFFFF_FFFF);
          else begin
            e = sb.pop_front();
            chk("bp_beat", {26'd0, cur}, {26'd0, e});
          end
        end
      end
      pv = s_valid; pr = s_ready; prev = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    beat_t e;

    //            st ab rdy  v  b  d  c  a  al
    vt[0]  = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0,0, 1'b0};
    vt[1]  = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0, 0,0, 1'b0};
    vt[2]  = '{1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 0,0, 1'b0};
    vt[3]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 0,1, 1'b0};
    vt[4]  = '{1'b1,1'b0,1'b1, 1'b1,1'b1,1'b0, 0,2, 1'b0};
    vt[5]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 0,2, 1'b0};
    vt[6]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 0,3, 1'b1};
    vt[7]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 1,0, 1'b0};
    vt[8]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 1,1, 1'b0};
    vt[9]  = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 1,1, 1'b0};
    vt[10] = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 1,2, 1'b0};
    vt[11] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 0,0, 1'b0};
    vt[12] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 0,0, 1'b0};
    vt[13] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 0,0, 1'b0};
    vt[14] = '{1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 0,0, 1'b0};
    vt[15] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 0,0, 1'b0};

    // Reset state
    step();
    chk("rst_b", {b_valid, b_busy, b_done, b_c, b_a, b_al, b_cl}, 32'd0);
    chk("rst_s", {s_valid, s_busy, s_done, s_c, s_a, s_al, s_cl}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Vector table on the 3x4 instance: start/abort priorities, holds, abort at (1,2)
    for (int i = 0; i < 16; i++) begin
      s_start = vt[i].st; s_abort = vt[i].ab; s_ready = vt[i].rdy;
      step();
      chk($sformatf("vec%0d", i), {s_valid, s_busy, s_done, s_c, s_a, s_al},
          {vt[i].v, vt[i].b, vt[i].d, vt[i].c[1:0], vt[i].a[1:0], vt[i].al});
    end
    s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0;
    step();

    // Random backpressure sweep on 3x4 through the scoreboard
    for (int c = 0; c < SC; c++)
      for (int a = 0; a < SA; a++) begin
        e.c = c[1:0]; e.a = a[1:0]; e.al = (a == SA - 1); e.cl = (c == SC - 1);
        sb.push_back(e);
      end
    mon_en = 1'b1;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int cyc = 0; cyc < 300 && !s_done; cyc++) begin
      s_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("bp_done_seen", {31'd0, s_done}, 32'd1);
    s_ready = 1'b0;
    step(); step(); step();
    mon_en = 1'b0;
    chk("bp_beats", s_beats, SC * SA);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_done_count", s_dones, 1);

    // Full default sweep with ready held high; start edge is cycle 0
    b_ready = 1'b1; b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("first_beat", {b_valid, b_busy, b_c, b_a}, {1'b1, 1'b1, 4'd0, 10'd0});
    bad = 0;
    for (int k = 0; k < NC * NA; k++) begin
      b_start = (k == 100);
      if (!(b_valid === 1'b1 && b_busy === 1'b1 && b_done === 1'b0 &&
            b_c === 4'(k / NA) && b_a === 10'(k % NA) &&
            b_al === ((k % NA) == NA - 1) && b_cl === ((k / NA) == NC - 1))) bad++;
`ifdef BAYES_IDX_ADDR_EN
      if (b_addr !== 14'(k)) bad++;
`endif
      if (k == NC * NA - 1)
        chk("last_beat", {b_c, b_a, b_al, b_cl}, {4'd9, 10'd783, 1'b1, 1'b1});
      step();
    end
    chk("sweep_bad_beats", bad, 0);
    chk("done_pulse", {b_done, b_valid, b_busy, b_c, b_a}, {1'b1, 1'b0, 1'b0, 4'd0, 10'd0});
`ifdef BAYES_IDX_ADDR_EN
    chk("addr_after_sweep", {18'd0, b_addr}, 32'd0);
`endif
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("done_cycle_start_ignored", {b_done, b_valid, b_busy}, 32'd0);
    step();
    chk("stay_idle", {b_done, b_valid, b_busy, b_c, b_a}, 32'd0);

    // Asynchronous reset between clock edges mid-sweep
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    step(); step();
    chk("pre_rst_beat", {b_valid, b_c, b_a}, {1'b1, 4'd0, 10'd2});
    #3 rst = 1'b1;
    #1;
    chk("async_rst", {b_valid, b_busy, b_done, b_c, b_a, b_al, b_cl}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_no_done", {b_done, b_valid}, 32'd0);
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    chk("restart_after_rst", {b_valid, b_busy, b_c, b_a}, {1'b1, 1'b1, 4'd0, 10'd0});
    step();
    chk("restart_second_beat", {b_valid, b_c, b_a}, {1'b1, 4'd0, 10'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
